posit32_regime_arbiter: RTL

Shares one posit32 regime-count datapath between N_REQ requesters. Each cycle it round-robin arbitrates valid requests, registers the winning posit, sign-normalises it, counts the regime run and returns regime length, signed regime value k and special-case flags, tagged with the requester ID. Sits between the decode-lane front ends and the exponent/fraction extraction stage. Two-stage valid/ready pipeline with full backpressure.

---
 rtl/posit_pkg.sv | 18 +
 rtl/posit32_regime_count.sv | 44 ++++
 rtl/posit32_regime_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared widths, constants and the regime-count result payload for the posit32 regime arbiter.
package posit_pkg;

  localparam int unsigned POSIT_W = 32;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned K_W     = 6;

  localparam logic [POSIT_W-1:0] NAR_32 = 32'h8000_0000;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [K_W-1:0]   k;
    logic             sign;
    logic             zero;
    logic             nar;
  } regime_result_t;

endpackage

// File: rtl/posit32_regime_count.sv
// Combinational posit32 regime decoder: sign-normalise, count the leading regime run, derive k.
module posit32_regime_count
  import posit_pkg::*;
(
  input  logic [POSIT_W-1:0] posit_i,
  output regime_result_t     result_o
);

  logic [POSIT_W-1:0] mag;
  logic               lead;
  logic               stop;
  logic [LEN_W-1:0]   run;
  logic               is_zero;
  logic               is_nar;

  always_comb begin
    mag     = posit_i[POSIT_W-1] ? (~posit_i + POSIT_W'(1)) : posit_i;
    lead    = mag[POSIT_W-2];
    is_zero = (posit_i == '0);
    is_nar  = (posit_i == NAR_32);
    run     = LEN_W'(1);
    stop    = 1'b0;
    // Run starts at bit 30 and ends at the first differing bit; all 31 bits equal saturates at 31.
    for (int i = POSIT_W - 3; i >= 0; i--) begin
      if (!stop) begin
        if (mag[i] == lead) begin
          run = run + LEN_W'(1);
        end else begin
          stop = 1'b1;
        end
      end
    end

    result_o      = '0;
    result_o.sign = posit_i[POSIT_W-1];
    result_o.zero = is_zero;
    result_o.nar  = is_nar;
    if (!(is_zero || is_nar)) begin
      result_o.len = run;
      result_o.k   = lead ? (K_W'(run) - K_W'(1)) : (K_W'(0) - K_W'(run));
    end
  end

endmodule

// File: rtl/posit32_regime_arbiter.sv
// Round-robin arbiter feeding a shared two-stage posit32 regime-count pipeline with valid/ready backpressure.
module posit32_regime_arbiter
  import posit_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*POSIT_W-1:0]   req_posit,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [LEN_W-1:0]           rsp_len,
  output logic [K_W-1:0]             rsp_k,
  output logic                       rsp_sign,
  output logic                       rsp_zero,
  output logic                       rsp_nar,
  output logic                       busy
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [POSIT_W-1:0] s1_posit_q, s1_posit_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic               s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]    s2_id_q, s2_id_d;
  regime_result_t     s2_res_q, s2_res_d;

  regime_result_t     s1_res;
  logic               s1_en_c, s2_en_c;
  logic [N_REQ-1:0]   grant_c;
  logic [ID_W-1:0]    grant_id_c;
  logic               found_c;
  logic               xfer_c;
  logic [POSIT_W-1:0] sel_posit_c;
  int unsigned        idx;

  assign s2_en_c = !s2_valid_q || rsp_ready;
  assign s1_en_c = !s1_valid_q || s2_en_c;

  // Round-robin scan from rr_ptr; grants are withheld while in reset so req_ready reads 0.
  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    found_c    = 1'b0;
    idx        = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(rr_ptr_q) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found_c && req_valid[idx]) begin
        found_c    = 1'b1;
        grant_id_c = ID_W'(idx);
      end
    end
    if (found_c && s1_en_c && rst_n) begin
      grant_c[grant_id_c] = 1'b1;
    end
  end

  assign req_ready   = grant_c;
  assign xfer_c      = |grant_c;
  assign sel_posit_c = req_posit[32'(grant_id_c)*POSIT_W +: POSIT_W];

  posit32_regime_count u_count (
    .posit_i  (s1_posit_q),
    .result_o (s1_res)
  );

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = xfer_c || (s1_valid_q && !s2_en_c);
    s1_posit_d = s1_posit_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_res_d   = s2_res_q;

    if (xfer_c) begin
      rr_ptr_d   = (32'(grant_id_c) == N_REQ - 1) ? '0 : grant_id_c + ID_W'(1);
      s1_posit_d = sel_posit_c;
      s1_id_d    = grant_id_c;
    end

    if (s2_en_c) begin
      s2_valid_d = s1_valid_q;
      s2_id_d    = s1_id_q;
      s2_res_d   = s1_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_posit_q <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_res_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_posit_q <= s1_posit_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_res_q   <= s2_res_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_len   = s2_res_q.len;
  assign rsp_k     = s2_res_q.k;
  assign rsp_sign  = s2_res_q.sign;
  assign rsp_zero  = s2_res_q.zero;
  assign rsp_nar   = s2_res_q.nar;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule
